// File: rtl/rapids_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : rapids_fetch_if
// Description : Handshake bundle between the rapids fetch front-end, the
//               instruction memory and the controlpath issue port.
// Revision    : 1.0 - initial release
// ============================================================================
interface rapids_fetch_if #(
    parameter int IW = 32,
    parameter int AW = 32
) ();

    // Instruction memory request/response channel
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;

    // Issue channel towards the controlpath
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr_data;
    logic [AW-1:0] instr_pc;

    // Fetch unit side
    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    // Memory / controlpath side
    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );

endinterface
`default_nettype wire

// File: rtl/rapids_fetch.sv
`default_nettype none
// ============================================================================
// Module      : rapids_fetch
// Description : Instruction fetch/issue front-end. Issues in-order fetch
//               requests under a credit limit, buffers responses in a
//               DEPTH-entry FIFO tagged with their PC, and presents them to
//               the controlpath. A redirect flushes the buffer and discards
//               every response still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module rapids_fetch #(
    parameter int             IW       = 32,
    parameter int             AW       = 32,
    parameter int             DEPTH    = 4,
    parameter int             PC_STEP  = 4,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    rapids_fetch_if.master                bus,
    input  wire logic                     redirect_valid,
    input  wire logic [AW-1:0]            redirect_pc,
    output logic      [$clog2(DEPTH):0]   occupancy,
    output logic      [31:0]              issued_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SUM_W = c_CNT_W + 1;

    localparam logic [c_SUM_W-1:0] c_DEPTH_SUM = c_SUM_W'(DEPTH);
    localparam logic [AW-1:0]      c_PC_STEP   = AW'(PC_STEP);

    // Buffer storage: instruction word and the PC it was fetched from
    logic [IW-1:0]        r_data_mem [DEPTH];
    logic [AW-1:0]        r_pc_mem   [DEPTH];

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   r_outstanding;
    logic [c_CNT_W-1:0]   r_drop_cnt;
    logic [AW-1:0]        r_fetch_pc;
    logic [AW-1:0]        r_rsp_pc;
    logic [31:0]          r_issued_count;

    logic [c_SUM_W-1:0]   w_credit_sum;
    logic                 w_req_valid;
    logic                 w_req_fire;
    logic                 w_rsp_accept;
    logic                 w_rsp_drop;
    logic                 w_push;
    logic                 w_empty;
    logic                 w_instr_valid;
    logic                 w_pop;

    // Buffered plus in-flight entries never exceed DEPTH, so every response
    // that returns is guaranteed a free slot.
    assign w_credit_sum  = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req_valid   = (w_credit_sum < c_DEPTH_SUM) && !redirect_valid && rst_n;
    assign w_req_fire    = w_req_valid && bus.imem_req_ready;

    // A response with nothing outstanding is a protocol violation; ignore it
    // so the counters cannot underflow.
    assign w_rsp_accept  = bus.imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_drop    = w_rsp_accept && (redirect_valid || (r_drop_cnt != '0));
    assign w_push        = w_rsp_accept && !w_rsp_drop;

    assign w_empty       = (r_count == '0);
    assign w_instr_valid = !w_empty && !redirect_valid;
    assign w_pop         = w_instr_valid && bus.instr_ready;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_fetch_pc;
    assign bus.instr_valid    = w_instr_valid;
    assign bus.instr_data     = w_empty ? '0 : r_data_mem[r_rd_ptr];
    assign bus.instr_pc       = w_empty ? '0 : r_pc_mem[r_rd_ptr];
    assign occupancy          = r_count;
    assign issued_count       = r_issued_count;

    // Fetch address: jumps on redirect, otherwise advances per accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
        end else if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + c_PC_STEP;
        end
    end

    // PC tag for the next kept response; tracks fetch_pc in request order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_rsp_pc <= redirect_pc;
        end else if (w_push) begin
            r_rsp_pc <= r_rsp_pc + c_PC_STEP;
        end
    end

    // In-flight accounting; on redirect everything still in flight becomes
    // a response to discard (this already covers any earlier drop count).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            r_outstanding <= r_outstanding - c_CNT_W'(w_rsp_accept);
            r_drop_cnt    <= r_outstanding - c_CNT_W'(w_rsp_accept);
        end else begin
            r_outstanding <= r_outstanding + c_CNT_W'(w_req_fire) - c_CNT_W'(w_rsp_accept);
            if (w_rsp_accept && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Buffer write; contents need no reset because reads are gated by count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= bus.imem_rsp_data;
            r_pc_mem[r_wr_ptr]   <= r_rsp_pc;
        end
    end

    // Free-running count of instructions handed to the controlpath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued_count <= '0;
        end else if (w_pop) begin
            r_issued_count <= r_issued_count + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: doc/rapids_fetch.md
Name: rapids_fetch

Overview:
- Parametrised instruction fetch/issue front-end for the rapids core.
- Replaces the raw per-cycle instruction input with three parts:
  - a program counter;
  - a request/response interface to instruction memory;
  - a DEPTH-entry instruction buffer.
- Presents instructions to the controlpath with a valid/ready handshake.
- Supports branch redirect with flush and discard of in-flight responses.

Parameters:
- IW, 32, instruction width in bits.
- AW, 32, address/PC width in bits.
- DEPTH, 4, instruction buffer entries; power of two, >=2.
- PC_STEP, 4, PC increment per fetched instruction.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  AW  fetch address (current fetch_pc).
- imem_rsp_valid  input  1  response data valid; in order, one per accepted request.
- imem_rsp_data  input  IW  fetched instruction.
- instr_valid  output  1  buffer head valid.
- instr_ready  input  1  controlpath consumes head.
- instr_data  output  IW  head instruction.
- instr_pc  output  AW  PC of head instruction.
- redirect_valid  input  1  single-cycle branch redirect.
- redirect_pc  input  AW  new fetch target.
- occupancy  output  clog2(DEPTH)+1  buffered entries.
- issued_count  output  32  instructions issued since reset; wraps.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=rsp_pc=RESET_PC.
  - Buffer empty; outstanding=0; drop_cnt=0; issued_count=0.
  - Outputs: imem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0, occupancy=0.
  - Reset mid-transaction abandons all in-flight requests. The memory side is reset with the core.
- Request:
  - imem_req_valid = (occupancy + outstanding < DEPTH) && !redirect_valid && rst_n.
  - imem_addr = fetch_pc.
  - On valid&&ready: fetch_pc += PC_STEP, modulo 2^AW, wraps silently; outstanding++.
- Credit rule: occupancy+outstanding <= DEPTH always, so a response never finds the buffer full.
- Response, when imem_rsp_valid:
  - outstanding-- (net with a same-cycle request: +1-1 = unchanged).
  - If drop_cnt>0: data discarded, drop_cnt--.
  - Else: push {imem_rsp_data, rsp_pc}; rsp_pc += PC_STEP.
  - Response with outstanding==0 is a protocol error: ignored, flagged by bench assertion.
- Issue:
  - instr_valid = !empty && !redirect_valid.
  - instr_data/instr_pc come combinationally from the head entry. Zero when empty.
  - Pop on instr_valid&&instr_ready; issued_count++.
- Latency:
  - A response received in cycle M appears on instr_valid in M+1. No rsp-to-issue bypass.
  - Minimum request-to-issue is 2 cycles.
- Push and pop in the same cycle: occupancy unchanged, FIFO order preserved. Read/write pointers are log2(DEPTH) bits and wrap.
- Redirect (highest priority, one cycle):
  - Buffer cleared; pop suppressed; request suppressed.
  - fetch_pc <= redirect_pc; rsp_pc <= redirect_pc.
  - drop_cnt <= outstanding - imem_rsp_valid; any same-cycle response is discarded.
  - outstanding <= outstanding - imem_rsp_valid.
  - Existing drop_cnt is subsumed; it is already counted in outstanding.
- Back-to-back redirects: the later one wins; drop accounting stays exact.
- First request after redirect: in the next cycle, address redirect_pc.
- Stall: instr_ready=0 holds the head stable. Fetch continues until the credit rule blocks it.

Test Plan:
- Reset release, imem_req_ready=1, memory returns 0x1000_0000+n one cycle after each request, instr_ready=1 → instr_valid first high 2 cycles after first request. instr_pc sequence 0,4,8,…; issued_count increments each cycle.
- DEPTH=4, instr_ready=0, memory always ready → exactly 4 requests (addr 0,4,8,12), then imem_req_valid=0. occupancy=4; instr_pc=0 held stable. Raising instr_ready resumes one request per pop.
- 3 requests outstanding (responses delayed 5 cycles), redirect_pc=0x200 → 3 late responses dropped, none issued. Next request addr 0x200; first issued instr_pc=0x200.
- Redirect in the same cycle as a response and a pending pop → response dropped, no issue, issued_count unchanged. drop_cnt = outstanding-1.
- AW=8, RESET_PC=0xF8, PC_STEP=4 → addresses F8, FC, 00, 04. instr_pc follows the same wrap.
- Assert rst_n low with 2 outstanding and 2 buffered → all outputs 0 immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC.
